// File: rtl/trax_neighbour_fetch.sv
// Board store and neighbour fetcher feeding the Trax tile legality checker.
// Optional macro OCCUPIED_CHECK_EN: reject queries whose target cell is already occupied.
module trax_neighbour_fetch #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = 3,
  parameter int CW   = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [2:0]    wr_tile,
  input  logic          q_valid,
  output logic          q_ready,
  input  logic [RW-1:0] q_row,
  input  logic [CW-1:0] q_col,
  output logic [2:0]    up_tile,
  output logic [2:0]    down_tile,
  output logic [2:0]    left_tile,
  output logic [2:0]    right_tile,
  output logic          start_signal,
  input  logic [5:0]    tile_type_in,
  input  logic          endsignal_in,
  output logic          rsp_valid,
  output logic [5:0]    rsp_mask,
  output logic          rsp_any,
  output logic          rsp_err
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SELF, RD_UP, RD_DOWN, RD_LEFT, RD_RIGHT, START, CAPTURE, REJECT
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      board_r [CELLS];
  logic [RW-1:0]   q_row_r;
  logic [CW-1:0]   q_col_r;
  logic            q_oor_s, wr_ok_s, rd_ok_s;
  logic [IW-1:0]   wr_idx_s, rd_idx_s;
  logic [RW-1:0]   rd_row_s;
  logic [CW-1:0]   rd_col_s;
  logic [2:0]      rd_data_s;

  assign q_ready = (state_r == IDLE);

  // Range checks and flat cell index for the write port and incoming query
  always_comb begin
    q_oor_s  = (int'(q_row) >= ROWS) || (int'(q_col) >= COLS);
    wr_ok_s  = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    wr_idx_s = IW'(int'(wr_row) * COLS + int'(wr_col));
  end

  // Single read port: address chosen by state; off-board neighbours read as empty
  always_comb begin
    rd_ok_s  = 1'b0;
    rd_row_s = q_row_r;
    rd_col_s = q_col_r;
    case (state_r)
      RD_SELF:  rd_ok_s = 1'b1;
      RD_UP:    begin rd_ok_s = (q_row_r != {RW{1'b0}}); rd_row_s = q_row_r - RW'(1); end
      RD_DOWN:  begin rd_ok_s = (q_row_r != ROW_LAST);   rd_row_s = q_row_r + RW'(1); end
      RD_LEFT:  begin rd_ok_s = (q_col_r != {CW{1'b0}}); rd_col_s = q_col_r - CW'(1); end
      RD_RIGHT: begin rd_ok_s = (q_col_r != COL_LAST);   rd_col_s = q_col_r + CW'(1); end
      default:  rd_ok_s = 1'b0;
    endcase
    rd_idx_s  = IW'(int'(rd_row_s) * COLS + int'(rd_col_s));
    rd_data_s = rd_ok_s ? board_r[rd_idx_s] : 3'd0;
  end

  // Board storage; a same-cycle read sees the contents before this write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) board_r[i] <= 3'd0;
    end else if (wr_ok_s) begin
      board_r[wr_idx_s] <= (wr_tile == 3'd7) ? 3'd0 : wr_tile;
    end
  end

  // Query coordinates latched on acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      q_row_r <= {RW{1'b0}};
      q_col_r <= {CW{1'b0}};
    end else if (q_ready && q_valid) begin
      q_row_r <= q_row;
      q_col_r <= q_col;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (q_valid) begin
          if (q_oor_s) state_s = REJECT;
`ifdef OCCUPIED_CHECK_EN
          else         state_s = RD_SELF;
`else
          else         state_s = RD_UP;
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef OCCUPIED_CHECK_EN
      RD_SELF: begin
        if (rd_data_s != 3'd0) state_s = IDLE;
        else                   state_s = RD_UP;
      end
`endif
      RD_UP:    state_s = RD_DOWN;
      RD_DOWN:  state_s = RD_LEFT;
      RD_LEFT:  state_s = RD_RIGHT;
      RD_RIGHT: state_s = START;
      START:    state_s = CAPTURE;
      CAPTURE:  state_s = IDLE;
      REJECT:   state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // Registered neighbour, start and response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      up_tile      <= 3'd0;
      down_tile    <= 3'd0;
      left_tile    <= 3'd0;
      right_tile   <= 3'd0;
      start_signal <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_mask     <= 6'd0;
      rsp_any      <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      start_signal <= (state_s == START);
      rsp_valid    <= 1'b0;
      case (state_r)
        RD_UP:    up_tile    <= rd_data_s;
        RD_DOWN:  down_tile  <= rd_data_s;
        RD_LEFT:  left_tile  <= rd_data_s;
        RD_RIGHT: right_tile <= rd_data_s;
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_mask  <= tile_type_in;
          rsp_any   <= endsignal_in && (tile_type_in != 6'd0);
          rsp_err   <= 1'b0;
        end
        REJECT: begin
          rsp_valid <= 1'b1;
          rsp_mask  <= 6'd0;
          rsp_any   <= 1'b0;
          rsp_err   <= 1'b1;
        end
`ifdef OCCUPIED_CHECK_EN
        RD_SELF: begin
          if (rd_data_s != 3'd0) begin
            rsp_valid <= 1'b1;
            rsp_mask  <= 6'd0;
            rsp_any   <= 1'b0;
            rsp_err   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trax_neighbour_fetch.sv
// Randomised bench for trax_neighbour_fetch against a cycle-indexed board model.
module tb_trax_neighbour_fetch;
  localparam int ROWS = 8, COLS = 8, RW = 4, CW = 4;
`ifdef OCCUPIED_CHECK_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 0;
`endif

  logic clock = 1'b0;
  logic reset, wr_en, q_valid, q_ready, start_signal, endsignal_in;
  logic rsp_valid, rsp_any, rsp_err;
  logic [RW-1:0] wr_row, q_row;
  logic [CW-1:0] wr_col, q_col;
  logic [2:0] wr_tile, up_tile, down_tile, left_tile, right_tile;
  logic [5:0] tile_type_in, rsp_mask;

  trax_neighbour_fetch #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_tile(wr_tile), .q_valid(q_valid), .q_ready(q_ready), .q_row(q_row), .q_col(q_col),
    .up_tile(up_tile), .down_tile(down_tile), .left_tile(left_tile), .right_tile(right_tile),
    .start_signal(start_signal), .tile_type_in(tile_type_in), .endsignal_in(endsignal_in),
    .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_any(rsp_any), .rsp_err(rsp_err));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int board_m [ROWS][COLS];
  int nb_m [4];
  int mask_m = 0, any_m = 0, err_m = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nb_tile(input int r, input int c, input int dir);
    int rr = r, cc = c;
    case (dir)
      0: rr = r - 1;
      1: rr = r + 1;
      2: cc = c - 1;
      default: cc = c + 1;
    endcase
    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) return 0;
    return board_m[rr][cc];
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Drive a write for the current cycle and update the model as the edge would
  task automatic set_write(input bit en, input int r, input int c, input int t);
    wr_en = en; wr_row = RW'(r); wr_col = CW'(c); wr_tile = 3'(t);
    if (en && r < ROWS && c < COLS) board_m[r][c] = (t == 7) ? 0 : t;
  endtask

  task automatic wr_cell(input int r, input int c, input int t);
    set_write(1'b1, r, c, t);
    step;
    set_write(1'b0, 0, 0, 0);
  endtask

  task automatic check_nb(input string tag, input int e [4]);
    check_value({tag, "_up"},    32'(up_tile),    32'(e[0]));
    check_value({tag, "_down"},  32'(down_tile),  32'(e[1]));
    check_value({tag, "_left"},  32'(left_tile),  32'(e[2]));
    check_value({tag, "_right"}, 32'(right_tile), 32'(e[3]));
  endtask

  // One query; fcyc>=0 forces a write in that cycle, rnd enables random writes elsewhere
  task automatic do_query(input int r, input int c, input int fcyc, input int fr,
                          input int fc, input int ft, input bit rnd);
    bit oor = (r >= ROWS) || (c >= COLS);
    bit rej = 1'b0;
    int exp_nb [4];
    int start_c, rsp_c, w;
    exp_nb = nb_m;
    start_c = oor ? -1 : BASE + 5;
    rsp_c   = oor ? 2 : BASE + 7;
    w = 0;
    while (q_ready !== 1'b1 && w < 20) begin step; w++; end
    check_value("q_ready_idle", 32'(q_ready), 32'd1);
    check_value("rsp_mask_hold", 32'(rsp_mask), 32'(mask_m));
    check_value("rsp_err_hold", 32'(rsp_err), 32'(err_m));
    check_nb("nb_hold", nb_m);
    for (int k = 0; k <= rsp_c; k++) begin
      if (k > 0) begin
        check_value("start", 32'(start_signal), 32'(k == start_c));
        check_value("rsp_valid", 32'(rsp_valid), 32'(k == rsp_c));
        check_value("q_ready", 32'(q_ready), 32'(k == rsp_c));
      end
      if (k == start_c) check_nb("nb_start", exp_nb);
      if (k == rsp_c) begin
        check_value("rsp_mask", 32'(rsp_mask), 32'(mask_m));
        check_value("rsp_any", 32'(rsp_any), 32'(any_m));
        check_value("rsp_err", 32'(rsp_err), 32'(err_m));
        check_nb("nb_rsp", nb_m);
      end
      if (oor && k == 0) begin mask_m = 0; any_m = 0; err_m = 1; end
      if (!oor && !rej) begin
        if (BASE == 1 && k == 1 && board_m[r][c] != 0) begin
          rej = 1'b1; start_c = -1; rsp_c = 2;
          mask_m = 0; any_m = 0; err_m = 1;
        end
        for (int d = 0; d < 4; d++)
          if (k == BASE + 1 + d) exp_nb[d] = nb_tile(r, c, d);
      end
      q_valid = (k == 0); q_row = RW'(r); q_col = CW'(c);
      tile_type_in = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) tile_type_in = 6'd0;
      endsignal_in = 1'($urandom_range(0, 1));
      if (!oor && !rej && k == BASE + 6) begin
        mask_m = int'(tile_type_in);
        any_m  = (endsignal_in && tile_type_in != 6'd0) ? 1 : 0;
        err_m  = 0;
        nb_m   = exp_nb;
      end
      if (k == fcyc) set_write(1'b1, fr, fc, ft);
      else if (rnd && $urandom_range(0, 1) == 1)
        set_write(1'b1, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 7));
      else set_write(1'b0, 0, 0, 0);
      step;
    end
    q_valid = 1'b0;
    set_write(1'b0, 0, 0, 0);
  endtask

  task automatic clear_model;
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) board_m[i][j] = 0;
    for (int d = 0; d < 4; d++) nb_m[d] = 0;
    mask_m = 0; any_m = 0; err_m = 0;
  endtask

  initial begin
    reset = 1'b1; q_valid = 1'b0; q_row = '0; q_col = '0;
    tile_type_in = 6'd0; endsignal_in = 1'b0;
    set_write(1'b0, 0, 0, 0);
    clear_model();
    step; step;
    reset = 1'b0;
    check_value("rst_q_ready", 32'(q_ready), 32'd1);
    check_value("rst_start", 32'(start_signal), 32'd0);
    check_value("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_value("rst_rsp_any", 32'(rsp_any), 32'd0);
    check_nb("rst", nb_m);

    do_query(3, 3, -1, 0, 0, 0, 1'b0);
    wr_cell(2, 3, 3); wr_cell(4, 3, 2); wr_cell(3, 2, 4); wr_cell(3, 4, 1);
    do_query(3, 3, -1, 0, 0, 0, 1'b0);
    wr_cell(1, 0, 5); wr_cell(0, 1, 6);
    do_query(0, 0, -1, 0, 0, 0, 1'b0);
    do_query(8, 2, -1, 0, 0, 0, 1'b0);
    do_query(2, 9, -1, 0, 0, 0, 1'b0);
    wr_cell(2, 3, 1);
    do_query(3, 3, BASE + 1, 2, 3, 4, 1'b0);
    do_query(3, 3, -1, 0, 0, 0, 1'b0);
    wr_cell(7, 6, 5); wr_cell(7, 6, 7);
    do_query(7, 7, -1, 0, 0, 0, 1'b0);
    wr_cell(8, 1, 3); wr_cell(1, 9, 2);
    do_query(3, 1, -1, 0, 0, 0, 1'b0);
    wr_cell(5, 5, 3);
    do_query(5, 5, -1, 0, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++)
      do_query($urandom_range(0, 8), $urandom_range(0, 8), -1, 0, 0, 0, 1'b1);

    // Reset arriving in RD_LEFT aborts the query and clears the board
    q_valid = 1'b1; q_row = RW'(3); q_col = CW'(3);
    step;
    q_valid = 1'b0;
    step; step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    clear_model();
    check_value("abort_q_ready", 32'(q_ready), 32'd1);
    check_value("abort_rsp_err", 32'(rsp_err), 32'd0);
    check_value("abort_rsp_mask", 32'(rsp_mask), 32'd0);
    check_nb("abort", nb_m);
    for (int k = 0; k < 6; k++) begin
      check_value("abort_start", 32'(start_signal), 32'd0);
      check_value("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      step;
    end
    do_query(3, 3, -1, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
